// File: rtl/cpu_trap_ctrl.sv
// Trap sequencer: arbitrates interrupt > exception > SRET at the retire boundary and redirects fetch.
// Latency: detect at N, exception capture pulse at N+1, redirect_valid from N+2, back to IDLE one cycle after redirect_ready.
// Backpressure: redirect_valid/flush/busy hold until redirect_ready; retire-boundary inputs are ignored while busy.
//
// Ports:
//   clk, rst (async, active-low)
//   inst_valid/inst_pc/inst_word and decode flags   instruction at the retire boundary
//   mem_misaligned/mem_is_store/mem_addr            data-side misalignment fault
//   global_ie/sie_mask/sip_pend/stvec/sepc          supervisor CSR state
//   exception/exc_cause/exc_pc/exc_value            capture pulse and payload for the CSR file
//   redirect_valid/redirect_pc/redirect_ready       fetch redirect handshake
//   flush/busy/in_trap                              pipeline control and handler-active flag
module cpu_trap_ctrl #(
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid,
   input  logic [31:0] inst_pc,
   input  logic [31:0] inst_word,
   input  logic        fetch_misaligned,
   input  logic        illegal_inst,
   input  logic        ecall,
   input  logic        ebreak,
   input  logic        sret,
   input  logic        mem_misaligned,
   input  logic        mem_is_store,
   input  logic [31:0] mem_addr,
   input  logic        global_ie,
   input  logic [31:0] sie_mask,
   input  logic [31:0] sip_pend,
   input  logic [31:0] stvec,
   input  logic [31:0] sepc,
   output logic        exception,
   output logic [31:0] exc_cause,
   output logic [31:0] exc_pc,
   output logic [31:0] exc_value,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        flush,
   output logic        busy,
   output logic        in_trap
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TRAP   = 2'd1,
      S_VECTOR = 2'd2,
      S_RET    = 2'd3
   } state_t;

   state_t      state_q,       state_d;
   logic        in_trap_q,     in_trap_d;
   logic [31:0] exc_cause_q,   exc_cause_d;
   logic [31:0] exc_pc_q,      exc_pc_d;
   logic [31:0] exc_value_q,   exc_value_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   // Interrupt selection: only SEI, SSI and STI are recognised, in that priority order.
   logic [31:0] pend;
   logic        irq_take;
   logic [3:0]  irq_code;
   logic        unused_pend;

   assign pend        = sip_pend & sie_mask;
   assign unused_pend = ^{pend[31:10], pend[8:6], pend[4:2], pend[0]};
   // Interrupts stay masked for the whole handler, including nested exceptions.
   assign irq_take    = global_ie & ~in_trap_q & (pend[9] | pend[1] | pend[5]);

   always_comb begin
      irq_code = 4'd5;
      if (pend[9])      irq_code = 4'd9;
      else if (pend[1]) irq_code = 4'd1;
   end

   // Synchronous exception selection, highest priority first.
   logic        exc_take;
   logic [3:0]  exc_code;
   logic [31:0] exc_val;

   assign exc_take = fetch_misaligned | illegal_inst | ebreak | ecall | mem_misaligned;

   always_comb begin
      exc_code = 4'd0;
      exc_val  = 32'd0;
      if (fetch_misaligned) begin
         exc_code = 4'd0;
         exc_val  = inst_pc;
      end else if (illegal_inst) begin
         exc_code = 4'd2;
         exc_val  = inst_word;
      end else if (ebreak) begin
         exc_code = 4'd3;
         exc_val  = inst_pc;
      end else if (ecall) begin
         exc_code = 4'd9;
         exc_val  = 32'd0;
      end else if (mem_misaligned) begin
         exc_code = mem_is_store ? 4'd6 : 4'd4;
         exc_val  = mem_addr;
      end
   end

   // Trap target: vectored offset applies to interrupts only, and only for MODE=1.
   logic [31:0] vec_base;
   logic [31:0] vec_target;

   assign vec_base   = {stvec[31:2], 2'b00};
   assign vec_target = (VECTORED_EN && (stvec[1:0] == 2'b01) && irq_take)
                       ? vec_base + {26'd0, irq_code, 2'b00}
                       : vec_base;

   always_comb begin
      state_d        = state_q;
      in_trap_d      = in_trap_q;
      exc_cause_d    = exc_cause_q;
      exc_pc_d       = exc_pc_q;
      exc_value_d    = exc_value_q;
      redirect_pc_d  = redirect_pc_q;
      exception      = 1'b0;
      redirect_valid = 1'b0;
      flush          = 1'b0;
      busy           = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (inst_valid) begin
               if (irq_take || exc_take) begin
                  state_d       = S_TRAP;
                  in_trap_d     = 1'b1;
                  exc_pc_d      = inst_pc;
                  exc_cause_d   = irq_take ? {1'b1, 27'd0, irq_code} : {28'd0, exc_code};
                  exc_value_d   = irq_take ? 32'd0 : exc_val;
                  redirect_pc_d = vec_target;
               end else if (sret) begin
                  state_d       = S_RET;
                  redirect_pc_d = sepc;
               end
            end
         end
         S_TRAP: begin
            exception = 1'b1;
            busy      = 1'b1;
            state_d   = S_VECTOR;
         end
         S_VECTOR: begin
            redirect_valid = 1'b1;
            flush          = 1'b1;
            busy           = 1'b1;
            if (redirect_ready) state_d = S_IDLE;
         end
         S_RET: begin
            redirect_valid = 1'b1;
            flush          = 1'b1;
            busy           = 1'b1;
            if (redirect_ready) begin
               state_d   = S_IDLE;
               in_trap_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         in_trap_q     <= 1'b0;
         exc_cause_q   <= 32'd0;
         exc_pc_q      <= 32'd0;
         exc_value_q   <= 32'd0;
         redirect_pc_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         in_trap_q     <= in_trap_d;
         exc_cause_q   <= exc_cause_d;
         exc_pc_q      <= exc_pc_d;
         exc_value_q   <= exc_value_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign exc_cause   = exc_cause_q;
   assign exc_pc      = exc_pc_q;
   assign exc_value   = exc_value_q;
   assign redirect_pc = redirect_pc_q;
   assign in_trap     = in_trap_q;

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
module tb_cpu_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst_word;
   logic        fetch_misaligned, illegal_inst, ecall, ebreak, sret;
   logic        mem_misaligned, mem_is_store;
   logic [31:0] mem_addr;
   logic        global_ie;
   logic [31:0] sie_mask, sip_pend, stvec, sepc;
   logic        redirect_ready;

   logic        exception0, redirect_valid0, flush0, busy0, in_trap0;
   logic [31:0] exc_cause0, exc_pc0, exc_value0, redirect_pc0;
   logic        exception1, redirect_valid1, flush1, busy1, in_trap1;
   logic [31:0] exc_cause1, exc_pc1, exc_value1, redirect_pc1;

   always #5 clk = ~clk;

   cpu_trap_ctrl #(.VECTORED_EN(1'b1)) dut0 (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_word(inst_word),
      .fetch_misaligned(fetch_misaligned), .illegal_inst(illegal_inst), .ecall(ecall),
      .ebreak(ebreak), .sret(sret), .mem_misaligned(mem_misaligned), .mem_is_store(mem_is_store),
      .mem_addr(mem_addr), .global_ie(global_ie), .sie_mask(sie_mask), .sip_pend(sip_pend),
      .stvec(stvec), .sepc(sepc), .exception(exception0), .exc_cause(exc_cause0),
      .exc_pc(exc_pc0), .exc_value(exc_value0), .redirect_valid(redirect_valid0),
      .redirect_pc(redirect_pc0), .redirect_ready(redirect_ready), .flush(flush0),
      .busy(busy0), .in_trap(in_trap0)
   );

   cpu_trap_ctrl #(.VECTORED_EN(1'b0)) dut1 (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_word(inst_word),
      .fetch_misaligned(fetch_misaligned), .illegal_inst(illegal_inst), .ecall(ecall),
      .ebreak(ebreak), .sret(sret), .mem_misaligned(mem_misaligned), .mem_is_store(mem_is_store),
      .mem_addr(mem_addr), .global_ie(global_ie), .sie_mask(sie_mask), .sip_pend(sip_pend),
      .stvec(stvec), .sepc(sepc), .exception(exception1), .exc_cause(exc_cause1),
      .exc_pc(exc_pc1), .exc_value(exc_value1), .redirect_valid(redirect_valid1),
      .redirect_pc(redirect_pc1), .redirect_ready(redirect_ready), .flush(flush1),
      .busy(busy1), .in_trap(in_trap1)
   );

   typedef struct {
      bit          is_ret;
      logic [31:0] cause;
      logic [31:0] pc;
      logic [31:0] value;
      logic [31:0] rpc_vec;
      logic [31:0] rpc_dir;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // flag bit positions: {fetch_mis, illegal, ebreak, ecall, sret, mem_mis, store}
   localparam logic [6:0] F_FM = 7'b1000000;
   localparam logic [6:0] F_IL = 7'b0100000;
   localparam logic [6:0] F_EB = 7'b0010000;
   localparam logic [6:0] F_EC = 7'b0001000;
   localparam logic [6:0] F_SR = 7'b0000100;
   localparam logic [6:0] F_MM = 7'b0000010;
   localparam logic [6:0] F_ST = 7'b0000001;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_trap(input logic [31:0] cause, pc, value, rv, rd);
      exp_t e;
      e.is_ret = 1'b0; e.cause = cause; e.pc = pc; e.value = value;
      e.rpc_vec = rv; e.rpc_dir = rd;
      exp_q.push_back(e);
   endtask

   task automatic push_ret(input logic [31:0] target);
      exp_t e;
      e.is_ret = 1'b1; e.cause = 32'd0; e.pc = 32'd0; e.value = 32'd0;
      e.rpc_vec = target; e.rpc_dir = target;
      exp_q.push_back(e);
   endtask

   task automatic clear_inst();
      inst_valid = 1'b0; fetch_misaligned = 1'b0; illegal_inst = 1'b0; ebreak = 1'b0;
      ecall = 1'b0; sret = 1'b0; mem_misaligned = 1'b0; mem_is_store = 1'b0;
   endtask

   // Presents one instruction for one cycle; returns at the negedge of the following cycle.
   task automatic fire(input logic [31:0] pc, word, input logic [6:0] fl, input logic [31:0] addr);
      @(negedge clk);
      inst_pc = pc; inst_word = word; mem_addr = addr;
      {fetch_misaligned, illegal_inst, ebreak, ecall, sret, mem_misaligned, mem_is_store} = fl;
      inst_valid = 1'b1;
      @(negedge clk);
      clear_inst();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy0 || redirect_valid0) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", {31'd0, busy0}, 32'd0);
   endtask

   task automatic do_sret(input logic [31:0] target);
      sepc = target;
      push_ret(target);
      fire(32'h0000_0F00, 32'h1020_0073, F_SR, 32'd0);
      wait_idle();
      chk("in_trap_after_sret", {31'd0, in_trap0}, 32'd0);
   endtask

   // Scoreboard monitor
   initial begin
      exp_t cur;
      bit   have = 1'b0;
      logic prev_rv = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            have = 1'b0;
            prev_rv = 1'b0;
         end else begin
            if (exception0) begin
               chk("trap_expected", {31'd0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  cur = exp_q.pop_front();
                  have = 1'b1;
                  chk("kind_trap", {31'd0, cur.is_ret}, 32'd0);
                  chk("exc_cause", exc_cause0, cur.cause);
                  chk("exc_pc", exc_pc0, cur.pc);
                  chk("exc_value", exc_value0, cur.value);
                  chk("exception_dir", {31'd0, exception1}, 32'd1);
                  chk("exc_cause_dir", exc_cause1, cur.cause);
               end
            end
            if (redirect_valid0 && !prev_rv) begin
               if (!have) begin
                  chk("redirect_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                  if (exp_q.size() > 0) begin
                     cur = exp_q.pop_front();
                     have = 1'b1;
                     chk("kind_ret", {31'd0, cur.is_ret}, 32'd1);
                  end
               end
               if (have) begin
                  chk("redirect_pc_vec", redirect_pc0, cur.rpc_vec);
                  chk("redirect_pc_dir", redirect_pc1, cur.rpc_dir);
                  chk("redirect_valid_dir", {31'd0, redirect_valid1}, 32'd1);
                  chk("flush_busy_dir", {30'd0, flush1, busy1}, 32'd3);
                  have = 1'b0;
               end
            end
            prev_rv = redirect_valid0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      clear_inst();
      inst_pc = 32'd0; inst_word = 32'd0; mem_addr = 32'd0;
      global_ie = 1'b0; sie_mask = 32'd0; sip_pend = 32'd0;
      stvec = 32'h8000_0001; sepc = 32'd0; redirect_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_exception", {31'd0, exception0}, 32'd0);
      chk("rst_redirect_valid", {31'd0, redirect_valid0}, 32'd0);
      chk("rst_flush_busy", {30'd0, flush0, busy0}, 32'd0);
      chk("rst_in_trap", {31'd0, in_trap0}, 32'd0);
      chk("rst_exc_cause", exc_cause0, 32'd0);
      chk("rst_exc_pc", exc_pc0, 32'd0);
      chk("rst_exc_value", exc_value0, 32'd0);
      chk("rst_redirect_pc", redirect_pc0, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Illegal instruction, exceptions are never vectored; latency check
      push_trap(32'd2, 32'h100, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000);
      fire(32'h100, 32'hFFFF_FFFF, F_IL, 32'd0);
      chk("busy_at_n1", {31'd0, busy0}, 32'd1);
      chk("exception_at_n1", {31'd0, exception0}, 32'd1);
      @(negedge clk);
      chk("redirect_at_n2", {30'd0, redirect_valid0, flush0}, 32'd3);
      chk("in_trap_set", {31'd0, in_trap0}, 32'd1);
      @(negedge clk);
      chk("idle_at_n3", {31'd0, busy0}, 32'd0);
      do_sret(32'h200);

      // SEI beats ecall; pending lines drop after capture
      global_ie = 1'b1; sie_mask = 32'h222; sip_pend = 32'h222;
      push_trap(32'h8000_0009, 32'h300, 32'd0, 32'h8000_0024, 32'h8000_0000);
      fire(32'h300, 32'h0000_0073, F_EC, 32'd0);
      sip_pend = 32'd0;
      wait_idle();
      chk("in_trap_irq", {31'd0, in_trap0}, 32'd1);

      // Nested exception with redirect stalled; retire inputs ignored while waiting
      sip_pend = 32'h222;
      redirect_ready = 1'b0;
      push_trap(32'd2, 32'h400, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000);
      fire(32'h400, 32'h1234_5678, F_IL, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         inst_valid = 1'b1; illegal_inst = 1'b1; inst_pc = 32'h999;
         chk("wait_redirect_flush_busy", {29'd0, redirect_valid0, flush0, busy0}, 32'd7);
         chk("wait_no_repulse", {31'd0, exception0}, 32'd0);
      end
      clear_inst();
      redirect_ready = 1'b1;
      wait_idle();
      sip_pend = 32'd0;

      // Timer pending while in handler: no trap, then SRET, then timer taken
      sie_mask = 32'h20; sip_pend = 32'h20; global_ie = 1'b1;
      fire(32'h500, 32'h0000_0013, 7'd0, 32'd0);
      chk("masked_no_trap", {30'd0, busy0, exception0}, 32'd0);
      do_sret(32'h1234);
      push_trap(32'h8000_0005, 32'h1234, 32'd0, 32'h8000_0014, 32'h8000_0000);
      fire(32'h1234, 32'h0000_0013, 7'd0, 32'd0);
      wait_idle();
      global_ie = 1'b0; sip_pend = 32'd0; sie_mask = 32'd0;

      // Exception priority table
      push_trap(32'd0, 32'h202, 32'h202, 32'h8000_0000, 32'h8000_0000);
      fire(32'h202, 32'd0, F_FM | F_MM | F_ST, 32'h1003);
      wait_idle();
      push_trap(32'd6, 32'h600, 32'h1003, 32'h8000_0000, 32'h8000_0000);
      fire(32'h600, 32'd0, F_MM | F_ST, 32'h1003);
      wait_idle();
      push_trap(32'd4, 32'h604, 32'h2001, 32'h8000_0000, 32'h8000_0000);
      fire(32'h604, 32'd0, F_MM, 32'h2001);
      wait_idle();
      push_trap(32'd3, 32'h608, 32'h608, 32'h8000_0000, 32'h8000_0000);
      fire(32'h608, 32'd0, F_EB | F_EC | F_MM, 32'h3000);
      wait_idle();
      push_trap(32'd9, 32'h60C, 32'd0, 32'h8000_0000, 32'h8000_0000);
      fire(32'h60C, 32'd0, F_EC | F_MM, 32'h3000);
      wait_idle();
      push_trap(32'd2, 32'h610, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000);
      fire(32'h610, 32'hDEAD_BEEF, F_IL | F_EB | F_SR, 32'd0);
      wait_idle();

      // SRET out of handler and again with in_trap already clear
      do_sret(32'h700);
      do_sret(32'h800);

      // SSI over STI, MODE=2 treated as direct
      stvec = 32'h4000_0102; global_ie = 1'b1; sie_mask = 32'hFFFF_FFFF; sip_pend = 32'h22;
      push_trap(32'h8000_0001, 32'h880, 32'd0, 32'h4000_0100, 32'h4000_0100);
      fire(32'h880, 32'd0, F_SR, 32'd0);
      wait_idle();
      global_ie = 1'b0; sip_pend = 32'd0;

      // Reset while stalled in VECTOR
      redirect_ready = 1'b0;
      push_trap(32'd2, 32'h900, 32'h1, 32'h4000_0100, 32'h4000_0100);
      fire(32'h900, 32'h1, F_IL, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_redirect_flush_busy", {29'd0, redirect_valid0, flush0, busy0}, 32'd0);
      chk("arst_exc_in_trap", {30'd0, exception0, in_trap0}, 32'd0);
      chk("arst_redirect_pc", redirect_pc0, 32'd0);
      chk("arst_exc_cause", exc_cause0, 32'd0);
      chk("arst_dir_outputs", {29'd0, redirect_valid1, busy1, in_trap1}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      redirect_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {29'd0, busy0, redirect_valid0, in_trap0}, 32'd0);
      @(negedge clk);
      chk("post_rst_still_idle", {30'd0, busy0, exception0}, 32'd0);

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
